// File: rtl/follow_servo_ctrl.sv
// Blob-following wheel controller: SEARCH/TRACK debounce on frame strobes,
// blob-position steering to signed wheel speeds, and 50 Hz servo PWM.
module follow_servo_ctrl #(
    parameter int c_period      = 1_000_000,
    parameter int c_stop        = 75_000,
    parameter int c_step        = 2_500,
    parameter int c_max_speed   = 4,
    parameter int c_prox_stop   = 5,
    parameter int c_acq_frames  = 3,
    parameter int c_lost_frames = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_done,
    input  logic [7:0] centroid,
    input  logic [2:0] proximity,
    output logic       servo_l,
    output logic       servo_r,
    output logic [3:0] speed_l,
    output logic [3:0] speed_r,
    output logic [1:0] state
);
    localparam int CW = $clog2(c_period);
    localparam int FW = $clog2(((c_acq_frames > c_lost_frames) ? c_acq_frames : c_lost_frames) + 1);

    localparam logic signed [3:0] SP_P1 = 4'sd1;
    localparam logic signed [3:0] SP_M1 = -4'sd1;
    localparam logic signed [3:0] SP_P2 = 4'sd2;
    localparam logic signed [3:0] SP_M2 = -4'sd2;

    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, TRACK = 2'd2} state_t;

    state_t            r_state, w_state_nxt;
    logic [FW-1:0]     r_acq, r_lost, w_acq_nxt, w_lost_nxt;
    logic signed [3:0] r_spd_l, r_spd_r, w_spd_l_nxt, w_spd_r_nxt;
    logic signed [3:0] w_base, w_half, w_min1, w_trk_l, w_trk_r;
    logic              w_detect;
    logic [CW-1:0]     r_cnt, r_wid_l, r_wid_r, w_wid_l, w_wid_r;
    logic              r_servo_l, r_servo_r;

    assign w_detect = |centroid;

    always_comb begin
        if (int'(proximity) >= c_prox_stop)
            w_base = '0;
        else if (c_max_speed - int'(proximity) < 1)
            w_base = SP_P1;
        else
            w_base = 4'(c_max_speed - int'(proximity));
        w_half = w_base >>> 1;
        w_min1 = (w_base == 4'sd0) ? SP_P1 : w_base;
    end

    // Strip priority runs outward from the center: 4,3,5,2,6,1,7,0.
    always_comb begin
        w_trk_l = '0;
        w_trk_r = '0;
        if (centroid[4] || centroid[3]) begin
            w_trk_l = w_base;  w_trk_r = w_base;
        end else if (centroid[5]) begin
            w_trk_l = w_half;  w_trk_r = w_min1;
        end else if (centroid[2]) begin
            w_trk_l = w_min1;  w_trk_r = w_half;
        end else if (centroid[6]) begin
            w_trk_l = SP_M2;   w_trk_r = SP_P2;
        end else if (centroid[1]) begin
            w_trk_l = SP_P2;   w_trk_r = SP_M2;
        end else if (centroid[7]) begin
            w_trk_l = SP_M2;   w_trk_r = SP_P2;
        end else if (centroid[0]) begin
            w_trk_l = SP_P2;   w_trk_r = SP_M2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq;
        w_lost_nxt  = r_lost;
        w_spd_l_nxt = r_spd_l;
        w_spd_r_nxt = r_spd_r;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_acq_nxt   = '0;
            w_lost_nxt  = '0;
            w_spd_l_nxt = '0;
            w_spd_r_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SEARCH;
                    w_acq_nxt   = '0;
                    w_lost_nxt  = '0;
                    w_spd_l_nxt = SP_P1;
                    w_spd_r_nxt = SP_M1;
                end
                SEARCH: begin
                    if (frame_done) begin
                        if (!w_detect) begin
                            w_acq_nxt = '0;
                        end else if (int'(r_acq) + 1 >= c_acq_frames) begin
                            w_state_nxt = TRACK;
                            w_acq_nxt   = '0;
                            w_spd_l_nxt = w_trk_l;
                            w_spd_r_nxt = w_trk_r;
                        end else begin
                            w_acq_nxt = r_acq + 1'b1;
                        end
                    end
                end
                TRACK: begin
                    if (frame_done) begin
                        if (w_detect) begin
                            w_lost_nxt  = '0;
                            w_spd_l_nxt = w_trk_l;
                            w_spd_r_nxt = w_trk_r;
                        end else if (int'(r_lost) + 1 >= c_lost_frames) begin
                            w_state_nxt = SEARCH;
                            w_lost_nxt  = '0;
                            w_spd_l_nxt = SP_P1;
                            w_spd_r_nxt = SP_M1;
                        end else begin
                            w_lost_nxt = r_lost + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_spd_l_nxt = '0;
                    w_spd_r_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acq   <= '0;
            r_lost  <= '0;
            r_spd_l <= '0;
            r_spd_r <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acq   <= w_acq_nxt;
            r_lost  <= w_lost_nxt;
            r_spd_l <= w_spd_l_nxt;
            r_spd_r <= w_spd_r_nxt;
        end
    end

    // Right servo is mounted mirrored, so its speed term is subtracted.
    assign w_wid_l = CW'(c_stop + int'(r_spd_l) * c_step);
    assign w_wid_r = CW'(c_stop - int'(r_spd_r) * c_step);

    // Widths latch only on the wrap edge, so a speed update landing on that
    // same edge is seen one frame later and pulses are never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wid_l   <= CW'(c_stop);
            r_wid_r   <= CW'(c_stop);
            r_servo_l <= 1'b0;
            r_servo_r <= 1'b0;
        end else begin
            if (r_cnt == CW'(c_period - 1)) begin
                r_cnt   <= '0;
                r_wid_l <= w_wid_l;
                r_wid_r <= w_wid_r;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_servo_l <= (r_cnt < r_wid_l);
            r_servo_r <= (r_cnt < r_wid_r);
        end
    end

    assign servo_l = r_servo_l;
    assign servo_r = r_servo_r;
    assign speed_l = r_spd_l;
    assign speed_r = r_spd_r;
    assign state   = r_state;
endmodule

// File: tb/tb_follow_servo_ctrl.sv
// Directed bench for follow_servo_ctrl with a 100-cycle servo frame,
// stop width 50 and step 5.
module tb_follow_servo_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       frame_done = 1'b0;
    logic [7:0] centroid = '0;
    logic [2:0] proximity = '0;
    logic       servo_l, servo_r;
    logic [3:0] speed_l, speed_r;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    follow_servo_ctrl #(
        .c_period(100),
        .c_stop  (50),
        .c_step  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .frame_done(frame_done),
        .centroid  (centroid),
        .proximity (proximity),
        .servo_l   (servo_l),
        .servo_r   (servo_r),
        .speed_l   (speed_l),
        .speed_r   (speed_r),
        .state     (state)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Called on a falling edge; the strobe is sampled by the next rising edge.
    task automatic strobe(input logic [7:0] c, input logic [2:0] p);
        centroid   = c;
        proximity  = p;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    // Skip `skip` pulse starts, then count high cycles over one 100-cycle frame.
    task automatic measure(input int skip, output int hl, output int hr);
        logic prev;
        bit   seen;
        hl = 0;
        hr = 0;
        for (int s = 0; s <= skip; s++) begin
            prev = servo_l;
            seen = 1'b0;
            for (int k = 0; k < 300 && !seen; k++) begin
                @(negedge clk);
                if (servo_l && !prev) seen = 1'b1;
                prev = servo_l;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL measure_timeout: no servo_l rise in 300 cycles, required a rise");
                return;
            end
        end
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            hl += int'(servo_l);
            hr += int'(servo_r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d, want 0", state);
        end
        checks++;
        if (speed_l !== 4'd0 || speed_r !== 4'd0) begin
            errors++; $display("FAIL reset_speed: got %0d/%0d, want 0/0", $signed(speed_l), $signed(speed_r));
        end
        checks++;
        if (servo_l !== 1'b0 || servo_r !== 1'b0) begin
            errors++; $display("FAIL reset_servo: got %b/%b, want 0/0", servo_l, servo_r);
        end
    endtask

    task automatic test_search();
        int hl, hr;
        rst    = 1'b0;
        enable = 1'b1;
        measure(0, hl, hr);
        checks++;
        if (hl != 50 || hr != 50) begin
            errors++; $display("FAIL first_frame_width: got %0d/%0d, want 50/50", hl, hr);
        end
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL search_state: got %0d, want 1", state);
        end
        checks++;
        if (speed_l !== 4'd1 || speed_r !== 4'hF) begin
            errors++; $display("FAIL search_speed: got %0d/%0d, want 1/-1", $signed(speed_l), $signed(speed_r));
        end
        measure(0, hl, hr);
        checks++;
        if (hl != 55 || hr != 55) begin
            errors++; $display("FAIL search_width: got %0d/%0d, want 55/55", hl, hr);
        end
    endtask

    task automatic test_acquire();
        int hl, hr;
        strobe(8'h10, 3'd0);
        strobe(8'h10, 3'd0);
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL acquire_two_frames: got state %0d, want 1", state);
        end
        strobe(8'h10, 3'd0);
        checks++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL acquire_state: got %0d, want 2", state);
        end
        checks++;
        if (speed_l !== 4'd4 || speed_r !== 4'd4) begin
            errors++; $display("FAIL acquire_speed: got %0d/%0d, want 4/4", $signed(speed_l), $signed(speed_r));
        end
        measure(1, hl, hr);
        checks++;
        if (hl != 70 || hr != 30) begin
            errors++; $display("FAIL acquire_width: got %0d/%0d, want 70/30", hl, hr);
        end
    endtask

    task automatic test_steer();
        logic [7:0] cv[8] = '{8'h20, 8'h08, 8'h02, 8'h04, 8'h18, 8'hA0, 8'h40, 8'h81};
        logic [2:0] pv[8] = '{3'd2,  3'd6,  3'd0,  3'd1,  3'd3,  3'd7,  3'd0,  3'd2};
        int         el[8] = '{1,     0,     2,     3,     1,     0,     -2,    -2};
        int         er[8] = '{2,     0,     -2,    1,     1,     1,     2,     2};
        int hl, hr;
        for (int i = 0; i < 8; i++) begin
            strobe(cv[i], pv[i]);
            checks++;
            if (state !== 2'd2 || speed_l !== 4'(el[i]) || speed_r !== 4'(er[i])) begin
                errors++;
                $display("FAIL steer_%0d (c=%h p=%0d): got st%0d %0d/%0d, want st2 %0d/%0d",
                         i, cv[i], pv[i], state, $signed(speed_l), $signed(speed_r), el[i], er[i]);
            end
        end
        measure(1, hl, hr);
        checks++;
        if (hl != 40 || hr != 40) begin
            errors++; $display("FAIL steer_width: got %0d/%0d, want 40/40", hl, hr);
        end
    endtask

    task automatic test_lost();
        strobe(8'h10, 3'd1);
        for (int i = 0; i < 7; i++) begin
            strobe(8'h00, 3'd0);
            checks++;
            if (state !== 2'd2 || speed_l !== 4'd3 || speed_r !== 4'd3) begin
                errors++;
                $display("FAIL lost_hold_%0d: got st%0d %0d/%0d, want st2 3/3",
                         i, state, $signed(speed_l), $signed(speed_r));
            end
        end
        strobe(8'h00, 3'd0);
        checks++;
        if (state !== 2'd1 || speed_l !== 4'd1 || speed_r !== 4'hF) begin
            errors++;
            $display("FAIL lost_eighth: got st%0d %0d/%0d, want st1 1/-1", state, $signed(speed_l), $signed(speed_r));
        end
        strobe(8'h10, 3'd0);
        strobe(8'h10, 3'd0);
        strobe(8'h00, 3'd0);
        strobe(8'h10, 3'd0);
        strobe(8'h10, 3'd0);
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL acq_interrupted: got state %0d, want 1", state);
        end
        strobe(8'h08, 3'd0);
        checks++;
        if (state !== 2'd2 || speed_l !== 4'd4 || speed_r !== 4'd4) begin
            errors++;
            $display("FAIL reacquire: got st%0d %0d/%0d, want st2 4/4", state, $signed(speed_l), $signed(speed_r));
        end
    endtask

    task automatic test_wrap_coincide();
        int hl, hr;
        measure(1, hl, hr);
        checks++;
        if (hl != 70 || hr != 30) begin
            errors++; $display("FAIL pre_wrap_width: got %0d/%0d, want 70/30", hl, hr);
        end
        // measure() returns right after a wrap: next falling edge is counter=1,
        // 98 more land on counter=99 so the strobe is sampled on the wrap edge.
        @(negedge clk);
        repeat (98) @(negedge clk);
        strobe(8'h08, 3'd2);
        checks++;
        if (speed_l !== 4'd2 || speed_r !== 4'd2) begin
            errors++; $display("FAIL wrap_speed: got %0d/%0d, want 2/2", $signed(speed_l), $signed(speed_r));
        end
        measure(0, hl, hr);
        checks++;
        if (hl != 70 || hr != 30) begin
            errors++; $display("FAIL wrap_old_width: got %0d/%0d, want 70/30", hl, hr);
        end
        measure(0, hl, hr);
        checks++;
        if (hl != 60 || hr != 40) begin
            errors++; $display("FAIL wrap_new_width: got %0d/%0d, want 60/40", hl, hr);
        end
    endtask

    task automatic test_disable();
        int hl, hr;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || speed_l !== 4'd0 || speed_r !== 4'd0) begin
            errors++;
            $display("FAIL disable: got st%0d %0d/%0d, want st0 0/0", state, $signed(speed_l), $signed(speed_r));
        end
        strobe(8'h10, 3'd0);
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL disabled_strobe: got state %0d, want 0", state);
        end
        measure(1, hl, hr);
        checks++;
        if (hl != 50 || hr != 50) begin
            errors++; $display("FAIL disabled_width: got %0d/%0d, want 50/50", hl, hr);
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 2'd1) begin
            errors++; $display("FAIL reenable: got state %0d, want 1", state);
        end
    endtask

    task automatic test_async_reset();
        bit high = 1'b0;
        for (int k = 0; k < 200 && !high; k++) begin
            @(negedge clk);
            if (servo_l && servo_r) high = 1'b1;
        end
        checks++;
        if (!high) begin
            errors++; $display("FAIL async_wait: servo pulse not seen in 200 cycles, required high");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (servo_l !== 1'b0 || servo_r !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL async_reset: got %b/%b st%0d, want 0/0 st0", servo_l, servo_r, state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_search();
        test_acquire();
        test_steer();
        test_lost();
        test_wrap_coincide();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
